// File: rtl/floodit_pkg.sv
// Shared definitions for the flood-it game datapath.
//   MAX_SIZE : largest board edge in cells
//   COLOR_W  : bits per cell colour
//   IDX_W    : row/column index width (2**IDX_W >= MAX_SIZE)
//   state_e  : responder FSM states
//   in_bounds: true when (r, c) lies inside an sz x sz board
package floodit_pkg;

  localparam int MAX_SIZE = 26;
  localparam int COLOR_W  = 3;
  localparam int IDX_W    = 5;

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    GROW,
    FINISH
  } state_e;

  // Signed arguments let callers probe r-1 / c-1 at the board edge safely.
  function automatic logic in_bounds(input int r, input int c, input int sz);
    return (r >= 0) && (c >= 0) && (r < sz) && (c < sz);
  endfunction

endpackage

// File: rtl/ff_raster_cnt.sv
// Row/column raster counter over an sz x sz grid.
//   clk, rst_n : clock and asynchronous active-low reset
//   clear      : force the position back to (0,0); wins over en
//   en         : advance one cell, wrapping from (sz-1,sz-1) to (0,0)
//   sz         : current grid edge
//   row, col   : current position
//   last       : high while the position is (sz-1,sz-1)
module ff_raster_cnt
  import floodit_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  input  logic [IDX_W-1:0] sz,
  output logic [IDX_W-1:0] row,
  output logic [IDX_W-1:0] col,
  output logic             last
);

  logic [IDX_W-1:0] row_q, row_d;
  logic [IDX_W-1:0] col_q, col_d;
  logic             row_end, col_end;

  assign row_end = (row_q == sz - 1'b1);
  assign col_end = (col_q == sz - 1'b1);

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear) begin
      row_d = '0;
      col_d = '0;
    end else if (en) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row  = row_q;
  assign col  = col_q;
  assign last = row_end && col_end;

endmodule

// File: rtl/flood_fill_responder.sv
// Responder side of the colour-select handshake. Owns the board, flood-fills
// the region grown from the top-left cell, and reports moves and the win.
//   CLOCK, RESET_N        : clock, asynchronous active-low reset
//   SIZE, COLOR_NUM       : board edge and legal colour count, taken with START
//   LOAD_WE/ROW/COL/COLOR : board load port (honoured only while idle)
//   START                 : begin a new game, aborting any fill
//   SEL_SIG, SEL_COLOR    : colour-select request
//   CHANGING_COLOR        : busy while a fill runs
//   SEL_ACK, STARTED      : one-cycle pulses for accept / start complete
//   RD_ROW, RD_COL        : display read address
//   RD_COLOR              : registered cell colour, one cycle after address
//   MOVES, WON            : accepted move count (saturating) and win flag
module flood_fill_responder
  import floodit_pkg::*;
(
  input  logic               CLOCK,
  input  logic               RESET_N,
  input  logic [4:0]         SIZE,
  input  logic [3:0]         COLOR_NUM,
  input  logic               LOAD_WE,
  input  logic [IDX_W-1:0]   LOAD_ROW,
  input  logic [IDX_W-1:0]   LOAD_COL,
  input  logic [COLOR_W-1:0] LOAD_COLOR,
  input  logic               START,
  input  logic               SEL_SIG,
  input  logic [COLOR_W-1:0] SEL_COLOR,
  output logic               CHANGING_COLOR,
  output logic               SEL_ACK,
  output logic               STARTED,
  input  logic [IDX_W-1:0]   RD_ROW,
  input  logic [IDX_W-1:0]   RD_COL,
  output logic [COLOR_W-1:0] RD_COLOR,
  output logic [7:0]         MOVES,
  output logic               WON
);

  state_e               state_q, state_d;
  logic [COLOR_W-1:0]   board_q [MAX_SIZE][MAX_SIZE];
  logic [COLOR_W-1:0]   board_d [MAX_SIZE][MAX_SIZE];
  logic [MAX_SIZE-1:0]  owned_q [MAX_SIZE];
  logic [MAX_SIZE-1:0]  owned_d [MAX_SIZE];
  logic [IDX_W-1:0]     sz_q, sz_d;
  logic [3:0]           color_num_q, color_num_d;
  logic [COLOR_W-1:0]   cur_color_q, cur_color_d;
  logic [COLOR_W-1:0]   target_q, target_d;
  logic [COLOR_W-1:0]   rd_color_q, rd_color_d;
  logic [9:0]           owned_cnt_q, owned_cnt_d;
  logic [7:0]           moves_q, moves_d;
  logic                 won_q, won_d;
  logic                 ready_q, ready_d;
  logic                 changed_q, changed_d;
  logic                 from_init_q, from_init_d;
  logic                 changing_q, changing_d;
  logic                 sel_ack_q, sel_ack_d;
  logic                 started_q, started_d;

  logic [IDX_W-1:0]     row, col, row_up, row_dn, col_lf, col_rt, sz_clamped;
  logic                 last_cell, nb_owned, grow_claim, accept;
  logic                 rd_in_range, ld_in_range;
  logic [9:0]           sz_sq;

  ff_raster_cnt u_raster (
    .clk   (CLOCK),
    .rst_n (RESET_N),
    .clear (state_q != GROW),
    .en    (state_q == GROW),
    .sz    (sz_q),
    .row   (row),
    .col   (col),
    .last  (last_cell)
  );

  assign sz_clamped = (SIZE < IDX_W'(2))        ? IDX_W'(2) :
                      (SIZE > IDX_W'(MAX_SIZE)) ? IDX_W'(MAX_SIZE) : SIZE;
  assign sz_sq      = 10'(sz_q) * 10'(sz_q);

  // Neighbour indices are pinned at the array edge so they never leave the
  // storage; in_bounds() then decides whether that neighbour really counts.
  assign row_up = (row == '0) ? row : row - 1'b1;
  assign row_dn = (row == IDX_W'(MAX_SIZE - 1)) ? row : row + 1'b1;
  assign col_lf = (col == '0) ? col : col - 1'b1;
  assign col_rt = (col == IDX_W'(MAX_SIZE - 1)) ? col : col + 1'b1;

  assign nb_owned =
      (in_bounds(int'(row) - 1, int'(col), int'(sz_q)) && owned_q[row_up][col]) ||
      (in_bounds(int'(row) + 1, int'(col), int'(sz_q)) && owned_q[row_dn][col]) ||
      (in_bounds(int'(row), int'(col) - 1, int'(sz_q)) && owned_q[row][col_lf]) ||
      (in_bounds(int'(row), int'(col) + 1, int'(sz_q)) && owned_q[row][col_rt]);

  assign grow_claim = !owned_q[row][col] && (board_q[row][col] == target_q) && nb_owned;

  assign accept = (state_q == IDLE) && SEL_SIG && ready_q && !won_q &&
                  ({1'b0, SEL_COLOR} < color_num_q) && (SEL_COLOR != cur_color_q);

  assign rd_in_range = (RD_ROW < IDX_W'(MAX_SIZE)) && (RD_COL < IDX_W'(MAX_SIZE));
  assign ld_in_range = (LOAD_ROW < IDX_W'(MAX_SIZE)) && (LOAD_COL < IDX_W'(MAX_SIZE));

  // START overrides everything else, so a game restart can never be mixed
  // with a half-applied select or a board load in the same cycle.
  always_comb begin
    state_d     = state_q;
    board_d     = board_q;
    owned_d     = owned_q;
    sz_d        = sz_q;
    color_num_d = color_num_q;
    cur_color_d = cur_color_q;
    target_d    = target_q;
    owned_cnt_d = owned_cnt_q;
    moves_d     = moves_q;
    won_d       = won_q;
    ready_d     = ready_q;
    changed_d   = changed_q;
    from_init_d = from_init_q;
    changing_d  = changing_q;
    sel_ack_d   = 1'b0;
    started_d   = 1'b0;
    rd_color_d  = rd_in_range ? board_q[RD_ROW][RD_COL] : '0;

    if (START) begin
      state_d     = INIT;
      sz_d        = sz_clamped;
      color_num_d = COLOR_NUM;
    end else begin
      case (state_q)
        IDLE: begin
          if (LOAD_WE && ld_in_range) begin
            board_d[LOAD_ROW][LOAD_COL] = LOAD_COLOR;
          end
          if (accept) begin
            sel_ack_d   = 1'b1;
            target_d    = SEL_COLOR;
            cur_color_d = SEL_COLOR;
            moves_d     = (moves_q == 8'hFF) ? moves_q : moves_q + 8'd1;
            changed_d   = 1'b0;
            from_init_d = 1'b0;
            changing_d  = 1'b1;
            state_d     = GROW;
          end
        end
        INIT: begin
          owned_d       = '{default: '0};
          owned_d[0][0] = 1'b1;
          owned_cnt_d   = 10'd1;
          cur_color_d   = board_q[0][0];
          target_d      = board_q[0][0];
          moves_d       = 8'd0;
          won_d         = 1'b0;
          ready_d       = 1'b1;
          changed_d     = 1'b0;
          from_init_d   = 1'b1;
          changing_d    = 1'b1;
          state_d       = GROW;
        end
        GROW: begin
          if (owned_q[row][col]) begin
            board_d[row][col] = target_q;
          end else if (grow_claim) begin
            owned_d[row][col] = 1'b1;
            owned_cnt_d       = owned_cnt_q + 10'd1;
          end
          // A claim on the final cell itself also forces another pass, since
          // it may unlock cells already visited earlier in this pass.
          if (last_cell) begin
            changed_d = 1'b0;
            if (!(changed_q || grow_claim)) begin
              state_d = FINISH;
            end
          end else begin
            changed_d = changed_q || grow_claim;
          end
        end
        FINISH: begin
          won_d      = (owned_cnt_q == sz_sq);
          changing_d = 1'b0;
          started_d  = from_init_q;
          state_d    = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      board_q     <= '{default: '0};
      owned_q     <= '{default: '0};
      sz_q        <= '0;
      color_num_q <= '0;
      cur_color_q <= '0;
      target_q    <= '0;
      owned_cnt_q <= '0;
      moves_q     <= '0;
      won_q       <= 1'b0;
      ready_q     <= 1'b0;
      changed_q   <= 1'b0;
      from_init_q <= 1'b0;
      changing_q  <= 1'b0;
      sel_ack_q   <= 1'b0;
      started_q   <= 1'b0;
      rd_color_q  <= '0;
    end else begin
      state_q     <= state_d;
      board_q     <= board_d;
      owned_q     <= owned_d;
      sz_q        <= sz_d;
      color_num_q <= color_num_d;
      cur_color_q <= cur_color_d;
      target_q    <= target_d;
      owned_cnt_q <= owned_cnt_d;
      moves_q     <= moves_d;
      won_q       <= won_d;
      ready_q     <= ready_d;
      changed_q   <= changed_d;
      from_init_q <= from_init_d;
      changing_q  <= changing_d;
      sel_ack_q   <= sel_ack_d;
      started_q   <= started_d;
      rd_color_q  <= rd_color_d;
    end
  end

  assign CHANGING_COLOR = changing_q;
  assign SEL_ACK        = sel_ack_q;
  assign STARTED        = started_q;
  assign RD_COLOR       = rd_color_q;
  assign MOVES          = moves_q;
  assign WON            = won_q;

endmodule

// File: doc/flood_fill_responder.md
Name: flood_fill_responder

Overview:
- Responder end of the colour-select handshake. The selector raises a request with a colour; this block flood-fills the owned region from the top-left cell, then releases busy.
- Owns the board storage: a load port from the board generator and a read port for the VGA scanner.
- Reports the move count and the win condition. It sits between the selector, the board generator and the VGA display.

Parameters:
- MAX_SIZE, 26, maximum board edge in cells.
- COLOR_W, 3, bits per cell colour.
- IDX_W, 5, row/column index width (must satisfy 2^IDX_W >= MAX_SIZE).

Ports:
- CLOCK  in  1  single system clock; all logic is rising-edge.
- RESET_N  in  1  asynchronous, active-low reset.
- SIZE  in  5  board edge; sampled on START.
- COLOR_NUM  in  4  number of legal colours; sampled on START.
- LOAD_WE  in  1  write-enable for a board cell.
- LOAD_ROW, LOAD_COL  in  IDX_W each  write address.
- LOAD_COLOR  in  COLOR_W  write data.
- START  in  1  one-cycle pulse; begin a new game on the loaded board.
- SEL_SIG  in  1  colour-select request, level.
- SEL_COLOR  in  COLOR_W  requested colour.
- CHANGING_COLOR  out  1  busy; high from accept until the fill completes.
- SEL_ACK  out  1  one-cycle pulse when a request is accepted.
- STARTED  out  1  one-cycle pulse when START processing finishes.
- RD_ROW, RD_COL  in  IDX_W each  display read address.
- RD_COLOR  out  COLOR_W  registered cell colour, 1-cycle latency.
- MOVES  out  8  accepted moves, saturating at 255.
- WON  out  1  high when every cell of the SIZE x SIZE board is owned.

Behaviour:
- Reset (async, RESET_N=0) clears:
  - state to IDLE; CHANGING_COLOR, SEL_ACK, STARTED, WON to 0; MOVES to 0; RD_COLOR to 0.
  - all owned flags, cur_color, and the ready flag to 0.
  - Board contents are also cleared to 0.
- Storage: board[MAX_SIZE][MAX_SIZE] of COLOR_W bits, plus owned[MAX_SIZE][MAX_SIZE] of 1 bit.
- Load port:
  - LOAD_WE writes in IDLE only; it is ignored in any other state.
  - Addresses >= MAX_SIZE are ignored.
- Read port: RD_COLOR <= board[RD_ROW][RD_COL] every cycle. An out-of-range address returns 0.
- States: IDLE, INIT, GROW, FINISH.
- IDLE -> INIT on START.
  - START is honoured in any state and aborts any fill in progress.
  - START has priority over SEL_SIG and over LOAD_WE in the same cycle.
- INIT (1 cycle):
  - Latch SIZE clamped to [2, MAX_SIZE] into sz; latch COLOR_NUM.
  - Clear all owned flags, then set owned[0][0]=1 and owned_cnt=1.
  - cur_color = target = board[0][0]; MOVES = 0; WON = 0; ready = 1.
  - Go to GROW; CHANGING_COLOR = 1.
- IDLE -> GROW on a SEL_SIG accept. Accept only if all of:
  - ready = 1,
  - SEL_COLOR < COLOR_NUM,
  - SEL_COLOR != cur_color,
  - WON = 0.
- On accept:
  - SEL_ACK pulses.
  - target = cur_color = SEL_COLOR.
  - MOVES increments, saturating at 255.
  - CHANGING_COLOR rises on the next edge.
- Rejected requests get no ACK. Requests arriving while busy are ignored, not queued.
- GROW visits one cell per cycle in raster order over (r, c) in [0, sz-1]^2.
  - If owned: board = target.
  - Else if board == target and any in-bounds 4-neighbour (bounded by sz) is owned: set owned, board unchanged, owned_cnt++, changed = 1.
  - At cell (sz-1, sz-1):
    - if changed: clear changed and restart at (0,0);
    - else go to FINISH.
- Timing: each pass takes sz*sz cycles, with at least one pass per fill.
- FINISH (1 cycle):
  - WON = (owned_cnt == sz*sz), using a 10-bit compare.
  - CHANGING_COLOR = 0.
  - STARTED pulses if the fill came from INIT.
  - Go to IDLE.
- Widths: owned_cnt is 10 bits and never exceeds 676; sz*sz is computed in 10 bits.

Decomposition:
- Shared package (floodit_pkg):
  - COLOR_W, MAX_SIZE, IDX_W;
  - the state enum {IDLE, INIT, GROW, FINISH};
  - the helper function in_bounds(r, c, sz).
- Natural sub-module: ff_raster_cnt. It is a row/column raster counter with wrap and last-cell flag, reused by the VGA cell scanner.

Test Plan:
- Load 4x4, all cells 2; START -> one GROW pass of 16 cycles, then a second pass finds no change; STARTED pulses; WON=1; MOVES=0.
- Load 3x3 rows {0,1,1 / 1,1,1 / 2,2,2}; START; SEL_COLOR=1 -> SEL_ACK, MOVES=1, owned_cnt=6, WON=0; then SEL_COLOR=2 -> MOVES=2, WON=1, all RD_COLOR reads return 2.
- After START, SEL_COLOR == cur_color, or SEL_COLOR >= COLOR_NUM (e.g. 5 with COLOR_NUM=4) -> no SEL_ACK, CHANGING_COLOR stays 0, MOVES unchanged.
- SEL_SIG held while CHANGING_COLOR=1 with a new colour -> ignored until IDLE, then accepted exactly once; LOAD_WE during GROW leaves the board unchanged.
- START pulsed mid-GROW -> fill aborts, INIT next cycle, MOVES=0; RESET_N low mid-GROW -> all outputs 0 immediately, asynchronously.
- SIZE=30 and SIZE=1 -> clamped to 26 and 2; a single-colour 26x26 board gives WON=1, MOVES saturating at 255 after 256 alternating accepts on a 2-colour board.
